// File: rtl/hilo_div_unit_pkg.sv
// Shared types and sizing for the HI/LO divide unit.
package hilo_div_unit_pkg;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned DivCntW  = 6;

  typedef enum logic [1:0] {
    DivFree = 2'b00,
    DivOn   = 2'b01,
    DivEnd  = 2'b10
  } div_state_e;

endpackage

// File: rtl/hilo_div_unit_step.sv
// One radix-2 restoring division step: shift {rem,quo} left and trial-subtract the divisor.
module hilo_div_unit_step
  import hilo_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so the difference fits WIDTH+1 bits and its MSB is the sign.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle signed/unsigned restoring divider producing {remainder, quotient} for HI/LO.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic               accept;

  hilo_div_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Negating 0x8000_0000 wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    op1_neg = signed_i & opdata1_i[WIDTH-1];
    op2_neg = signed_i & opdata2_i[WIDTH-1];
    op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    accept  = start_i & ~annul_i;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      DivFree: begin
        if (accept) begin
          if (opdata2_i == '0) begin
            state_d  = DivEnd;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = op1_abs;
            divisor_d = op2_abs;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
          end
        end
      end
      DivOn: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DivEnd;
          result_d = {neg_rem_q ? (~step_rem + 1'b1) : step_rem,
                      neg_quo_q ? (~step_quo + 1'b1) : step_quo};
        end
      end
      DivEnd:  state_d = DivFree;
      default: state_d = DivFree;
    endcase

    // Flush wins over everything, including a completion on this very edge.
    if (annul_i) begin
      state_d  = DivFree;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    result_o = result_q;
    ready_o  = (state_q == DivEnd) & ~annul_i;
    stall_o  = ((state_q == DivFree) & accept) | (state_q == DivOn);
  end

endmodule
